// File: rtl/torus_pkg.sv
// Shared types and constants for the torus client port.
package torus_pkg;

    localparam int unsigned X_W   = 2;
    localparam int unsigned Y_W   = 2;
    localparam int unsigned D_W   = 32;
    localparam int unsigned MSG_W = X_W + Y_W + D_W;
    localparam int unsigned CNT_W = 16;

    localparam int unsigned ERR_OVF      = 0;
    localparam int unsigned ERR_MISROUTE = 1;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [D_W-1:0] data;
    } msg_t;

endpackage

// File: rtl/torus_client_port_if.sv
// Client-side handshake bundle: injection, ejection and backpressure signals.
interface torus_client_port_if #(
    parameter int unsigned X_W  = 2,
    parameter int unsigned Y_W  = 2,
    parameter int unsigned D_W  = 32,
    parameter int unsigned VC_W = 1
);
    logic            u_v;
    logic [X_W-1:0]  u_x;
    logic [Y_W-1:0]  u_y;
    logic [D_W-1:0]  u_data;
    logic            u_rdy;

    logic            i_v;
    logic [X_W-1:0]  i_x;
    logic [Y_W-1:0]  i_y;
    logic [D_W-1:0]  i_data;
    logic            i_ack;

    logic            o_v;
    logic [X_W-1:0]  o_x;
    logic [Y_W-1:0]  o_y;
    logic [D_W-1:0]  o_data;
    logic [VC_W-1:0] client_b;

    logic            d_v;
    logic [X_W-1:0]  d_x;
    logic [Y_W-1:0]  d_y;
    logic [D_W-1:0]  d_data;
    logic            d_rdy;

    // Environment side: client, switch and consumer.
    modport master (
        output u_v, u_x, u_y, u_data, i_ack, o_v, o_x, o_y, o_data, d_rdy,
        input  u_rdy, i_v, i_x, i_y, i_data, client_b, d_v, d_x, d_y, d_data
    );

    // Port side.
    modport slave (
        input  u_v, u_x, u_y, u_data, i_ack, o_v, o_x, o_y, o_data, d_rdy,
        output u_rdy, i_v, i_x, i_y, i_data, client_b, d_v, d_x, d_y, d_data
    );
endinterface

// File: rtl/torus_msg_fifo.sv
// Register-based message FIFO; push/pop arrive pre-qualified from the caller.
module torus_msg_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned MSG_W = 36
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [MSG_W-1:0]       wdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [MSG_W-1:0]       head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [MSG_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A push on a full FIFO is only legal alongside a pop; the head is read before the overwrite.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/torus_client_port.sv
// Client adapter for one torus node: injection FIFO toward the switch, skid buffer from it.
module torus_client_port
    import torus_pkg::*;
#(
    parameter int unsigned X_W   = 2,
    parameter int unsigned Y_W   = 2,
    parameter int unsigned D_W   = 32,
    parameter int unsigned VC_W  = 1,
    parameter int unsigned X     = 0,
    parameter int unsigned Y     = 0,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    torus_client_port_if.slave        bus,
    output logic [CNT_W-1:0]          inj_cnt,
    output logic [CNT_W-1:0]          ej_cnt,
    output logic [1:0]                err,
    output logic                      done
);
    localparam int unsigned M_W = X_W + Y_W + D_W;
    localparam int unsigned IW  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [D_W-1:0] data;
    } port_msg_t;

    port_msg_t inj_wdata, inj_head, ej_wdata, ej_head;
    logic      inj_full, inj_empty, inj_push, inj_pop;
    logic      ej_full, ej_empty, ej_push, ej_pop;
    logic      ovf, misroute;
    logic [IW-1:0] inj_count;
    logic [1:0]    ej_count;

    // Injection: no push while full, even with a concurrent pop.
    assign inj_push  = bus.u_v && !inj_full;
    assign inj_pop   = !inj_empty && bus.i_ack;
    assign inj_wdata = '{x: bus.u_x, y: bus.u_y, data: bus.u_data};

    torus_msg_fifo #(.DEPTH(DEPTH), .MSG_W(M_W)) u_inj (
        .clk   (clk),
        .rst   (rst),
        .push  (inj_push),
        .pop   (inj_pop),
        .wdata (inj_wdata),
        .full  (inj_full),
        .empty (inj_empty),
        .count (inj_count),
        .head  (inj_head)
    );

    assign bus.u_rdy  = !inj_full;
    assign bus.i_v    = !inj_empty;
    assign bus.i_x    = inj_head.x;
    assign bus.i_y    = inj_head.y;
    assign bus.i_data = inj_head.data;

    // Ejection: a delivery into a full buffer survives only if the consumer pops that cycle.
    assign ej_pop   = !ej_empty && bus.d_rdy;
    assign ej_push  = bus.o_v && (!ej_full || ej_pop);
    assign ovf      = bus.o_v && ej_full && !ej_pop;
    assign misroute = ej_push && ((bus.o_x != X_W'(X)) || (bus.o_y != Y_W'(Y)));
    assign ej_wdata = '{x: bus.o_x, y: bus.o_y, data: bus.o_data};

    torus_msg_fifo #(.DEPTH(2), .MSG_W(M_W)) u_ej (
        .clk   (clk),
        .rst   (rst),
        .push  (ej_push),
        .pop   (ej_pop),
        .wdata (ej_wdata),
        .full  (ej_full),
        .empty (ej_empty),
        .count (ej_count),
        .head  (ej_head)
    );

    assign bus.client_b = {VC_W{ej_count == 2'd2}};
    assign bus.d_v      = !ej_empty;
    assign bus.d_x      = ej_head.x;
    assign bus.d_y      = ej_head.y;
    assign bus.d_data   = ej_head.data;

    // Saturating stat counters and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_cnt <= '0;
            ej_cnt  <= '0;
            err     <= '0;
        end else begin
            if (inj_pop && (inj_cnt != '1)) inj_cnt <= inj_cnt + CNT_W'(1);
            if (ej_pop && (ej_cnt != '1))   ej_cnt  <= ej_cnt + CNT_W'(1);
            if (ovf)      err[ERR_OVF]      <= 1'b1;
            if (misroute) err[ERR_MISROUTE] <= 1'b1;
        end
    end

    assign done = (inj_count == '0) && ej_empty && !bus.u_v && !bus.o_v;

endmodule

// File: tb/tb_torus_client_port.sv
// Directed bench for torus_client_port with queue-based scoreboard on both output paths.
module tb_torus_client_port;
    import torus_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] inj_cnt, ej_cnt;
    logic [1:0]       err;
    logic             done;

    int   errors = 0;
    int   checks = 0;
    msg_t inj_q[$];
    msg_t ej_q[$];

    always #5 clk = ~clk;

    torus_client_port_if bus ();

    torus_client_port dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .inj_cnt (inj_cnt),
        .ej_cnt  (ej_cnt),
        .err     (err),
        .done    (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic msg_t mk(input logic [1:0] x, input logic [1:0] y, input logic [31:0] d);
        return '{x: x, y: y, data: d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    // Monitor: every accepted transfer on either output path is checked against its queue.
    always @(negedge clk) begin
        msg_t exp;
        if (rst) begin
            if (bus.i_v && bus.i_ack) begin
                if (inj_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL inj_msg: got unexpected %0h expected none", {bus.i_x, bus.i_y, bus.i_data});
                end else begin
                    exp = inj_q.pop_front();
                    chk("inj_msg", 64'({bus.i_x, bus.i_y, bus.i_data}), 64'(exp));
                end
            end
            if (bus.d_v && bus.d_rdy) begin
                if (ej_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ej_msg: got unexpected %0h expected none", {bus.d_x, bus.d_y, bus.d_data});
                end else begin
                    exp = ej_q.pop_front();
                    chk("ej_msg", 64'({bus.d_x, bus.d_y, bus.d_data}), 64'(exp));
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.u_v = 0; bus.u_x = 0; bus.u_y = 0; bus.u_data = 0; bus.i_ack = 0;
        bus.o_v = 0; bus.o_x = 0; bus.o_y = 0; bus.o_data = 0; bus.d_rdy = 0;
        #12;
        chk("rst_u_rdy", 64'(bus.u_rdy), 64'd1);
        chk("rst_i_v", 64'(bus.i_v), 64'd0);
        chk("rst_d_v", 64'(bus.d_v), 64'd0);
        chk("rst_client_b", 64'(bus.client_b), 64'd0);
        chk("rst_done", 64'(done), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Three messages held with no ack, then drained in order.
        bus.u_v = 1; bus.u_x = 2'd1; bus.u_y = 2'd0; bus.u_data = 32'hA;
        step();
        chk("t1_i_v_latency", 64'(bus.i_v), 64'd1);
        chk("t1_head_a", 64'(bus.i_data), 64'hA);
        bus.u_data = 32'hB;
        step();
        bus.u_data = 32'hC;
        step();
        bus.u_v = 0;
        #1;
        chk("t1_u_rdy", 64'(bus.u_rdy), 64'd1);
        chk("t1_head_stable", 64'({bus.i_x, bus.i_y, bus.i_data}), 64'(mk(2'd1, 2'd0, 32'hA)));
        chk("t1_not_done", 64'(done), 64'd0);
        inj_q.push_back(mk(2'd1, 2'd0, 32'hA));
        inj_q.push_back(mk(2'd1, 2'd0, 32'hB));
        inj_q.push_back(mk(2'd1, 2'd0, 32'hC));
        bus.i_ack = 1;
        repeat (3) step();
        bus.i_ack = 0;
        chk("t1_i_v_empty", 64'(bus.i_v), 64'd0);
        chk("t1_inj_cnt", 64'(inj_cnt), 64'd3);

        // Fill to DEPTH=4, fifth message held off until one pop frees a slot.
        bus.u_v = 1; bus.u_x = 2'd2; bus.u_y = 2'd1;
        for (int k = 0; k < 4; k++) begin
            bus.u_data = 32'h100 + 32'(k);
            step();
        end
        chk("t2_full_u_rdy", 64'(bus.u_rdy), 64'd0);
        bus.u_data = 32'h104;
        step();
        chk("t2_still_full", 64'(bus.u_rdy), 64'd0);
        inj_q.push_back(mk(2'd2, 2'd1, 32'h100));
        bus.i_ack = 1;
        step();
        bus.i_ack = 0;
        chk("t2_u_rdy_after_pop", 64'(bus.u_rdy), 64'd1);
        step();
        bus.u_v = 0;
        chk("t2_refull", 64'(bus.u_rdy), 64'd0);
        for (int k = 1; k < 5; k++) inj_q.push_back(mk(2'd2, 2'd1, 32'h100 + 32'(k)));
        bus.i_ack = 1;
        repeat (4) step();
        bus.i_ack = 0;
        chk("t2_drained", 64'(bus.i_v), 64'd0);
        chk("t2_inj_cnt", 64'(inj_cnt), 64'd8);

        // Ejection overflow: third delivery into a full buffer is dropped.
        bus.o_v = 1; bus.o_x = 2'd0; bus.o_y = 2'd0; bus.o_data = 32'hE0;
        step();
        chk("t3_client_b_1", 64'(bus.client_b), 64'd0);
        bus.o_data = 32'hE1;
        step();
        chk("t3_client_b_2", 64'(bus.client_b), 64'd1);
        bus.o_data = 32'hE2;
        step();
        bus.o_v = 0;
        chk("t3_err_ovf", 64'(err), 64'b01);
        chk("t3_d_data", 64'(bus.d_data), 64'hE0);
        ej_q.push_back(mk(2'd0, 2'd0, 32'hE0));
        ej_q.push_back(mk(2'd0, 2'd0, 32'hE1));
        bus.d_rdy = 1;
        repeat (2) step();
        bus.d_rdy = 0;
        chk("t3_d_v_empty", 64'(bus.d_v), 64'd0);
        chk("t3_ej_cnt", 64'(ej_cnt), 64'd2);

        // Same, but a consumer pop on the third cycle lets it in.
        do_reset();
        bus.o_v = 1; bus.o_data = 32'hE0;
        step();
        bus.o_data = 32'hE1;
        step();
        ej_q.push_back(mk(2'd0, 2'd0, 32'hE0));
        bus.o_data = 32'hE2; bus.d_rdy = 1;
        step();
        bus.o_v = 0; bus.d_rdy = 0;
        chk("t4_no_err", 64'(err), 64'd0);
        chk("t4_ej_cnt", 64'(ej_cnt), 64'd1);
        chk("t4_client_b", 64'(bus.client_b), 64'd1);
        chk("t4_head", 64'(bus.d_data), 64'hE1);
        ej_q.push_back(mk(2'd0, 2'd0, 32'hE1));
        ej_q.push_back(mk(2'd0, 2'd0, 32'hE2));
        bus.d_rdy = 1;
        repeat (2) step();
        bus.d_rdy = 0;
        chk("t4_ej_cnt_final", 64'(ej_cnt), 64'd3);

        // Misroute: stored anyway, error sticky.
        bus.o_v = 1; bus.o_x = 2'd1; bus.o_y = 2'd0; bus.o_data = 32'h55;
        step();
        bus.o_v = 0;
        chk("t5_err_mis", 64'(err), 64'b10);
        chk("t5_d_v", 64'(bus.d_v), 64'd1);
        chk("t5_d_msg", 64'({bus.d_x, bus.d_y, bus.d_data}), 64'(mk(2'd1, 2'd0, 32'h55)));
        ej_q.push_back(mk(2'd1, 2'd0, 32'h55));
        bus.d_rdy = 1;
        step();
        bus.d_rdy = 0;
        repeat (2) step();
        chk("t5_err_sticky", 64'(err), 64'b10);
        chk("t5_ej_cnt", 64'(ej_cnt), 64'd4);

        // Reset mid-operation with two messages queued in each path.
        bus.u_v = 1; bus.u_x = 2'd3; bus.u_y = 2'd3;
        for (int k = 0; k < 3; k++) begin
            bus.u_data = 32'hF0 + 32'(k);
            step();
        end
        bus.u_v = 0;
        inj_q.push_back(mk(2'd3, 2'd3, 32'hF0));
        bus.i_ack = 1;
        step();
        bus.i_ack = 0;
        bus.o_v = 1; bus.o_x = 2'd0; bus.o_y = 2'd0; bus.o_data = 32'hC0;
        step();
        bus.o_data = 32'hC1;
        step();
        bus.o_v = 0;
        chk("t6_pre_client_b", 64'(bus.client_b), 64'd1);
        chk("t6_pre_inj_cnt", 64'(inj_cnt), 64'd1);
        chk("t6_pre_i_v", 64'(bus.i_v), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_i_v", 64'(bus.i_v), 64'd0);
        chk("t6_d_v", 64'(bus.d_v), 64'd0);
        chk("t6_client_b", 64'(bus.client_b), 64'd0);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_counters", 64'({inj_cnt, ej_cnt}), 64'd0);
        chk("t6_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) step();
        chk("t6_post_i_v", 64'(bus.i_v), 64'd0);
        chk("t6_post_done", 64'(done), 64'd1);

        chk("inj_q_drained", 64'(inj_q.size()), 64'd0);
        chk("ej_q_drained", 64'(ej_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/torus_client_port.md
Name: torus_client_port

Overview:
- Client-side adapter for one torus switch node.
- Injection path: a FIFO that buffers client messages and presents the head message on the switch's i_v/i_x/i_y/i_data, popping on i_ack.
- Ejection path: a 2-entry skid buffer that captures switch deliveries (o_v plus the south-output message fields) and generates the registered client_b backpressure.
- Sits between the PE/traffic generator and the switch; provides a done flag and stat counters for the testbench.

Parameters:
X_W, 2, X address width
Y_W, 2, Y address width
D_W, 32, payload width
VC_W, 1, client_b width (all bits driven identically)
X, 0, X address of this node (misroute check)
Y, 0, Y address of this node (misroute check)
DEPTH, 4, injection FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
u_v  in  1  client message valid
u_x  in  X_W  client destination x
u_y  in  Y_W  client destination y
u_data  in  D_W  client payload
u_rdy  out  1  FIFO can accept (not full)
i_v  out  1  message offered to switch
i_x  out  X_W  offered x
i_y  out  Y_W  offered y
i_data  out  D_W  offered payload
i_ack  in  1  switch accepted offered message
o_v  in  1  switch delivers a message to this client
o_x  in  X_W  delivered x (switch south-out x)
o_y  in  Y_W  delivered y
o_data  in  D_W  delivered payload
client_b  out  VC_W  backpressure to switch
d_v  out  1  ejected message valid to consumer
d_x  out  X_W  ejected x
d_y  out  Y_W  ejected y
d_data  out  D_W  ejected payload
d_rdy  in  1  consumer ready
inj_cnt  out  16  messages accepted by switch (saturating)
ej_cnt  out  16  messages popped by consumer (saturating)
err  out  2  sticky; bit0 = overflow drop, bit1 = misroute
done  out  1  port idle

Behaviour:
- Reset (rst low, asynchronous): FIFO and skid buffer empty, counters 0, err 0. Outputs: u_rdy=1, i_v=0, d_v=0, client_b=0, done=1. Reset mid-operation discards all buffered messages.
- Injection push: on u_v && u_rdy. u_rdy = !full, from registered occupancy. No push while full, even if a pop occurs the same cycle.
- Injection offer: i_v = !empty; i_x/i_y/i_data = head entry, driven straight from registers.
  - Latency: push into empty FIFO gives i_v=1 on the next cycle.
  - Head stays stable while i_v && !i_ack.
- Injection pop: on i_v && i_ack. i_ack while i_v=0 is ignored.
- Simultaneous push and pop, not full: occupancy unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from a count register of width log2(DEPTH)+1.
- Ejection skid buffer: 2-entry FIFO, count in {0,1,2}.
  - Write on o_v. d_v = count!=0; head on d_x/d_y/d_data.
  - Pop on d_v && d_rdy.
  - client_b = {VC_W{count==2}}, a function of registered state only.
- Ejection edge cases:
  - o_v while count==2 and no pop: message dropped, err[0] set.
  - o_v while count==2 with pop in the same cycle: accepted, no error.
- Misroute: a write with (o_x,o_y) != (X,Y) sets err[1]; the message is still stored.
- Counters: inj_cnt increments on injection pop, ej_cnt on ejection pop; both saturate at 16'hFFFF.
- done = injection empty && ejection empty && !u_v && !o_v (combinational).

Decomposition:
- Shared package torus_pkg:
  - msg_t packed struct {x, y, data}, parameterised via localparam widths.
  - MSG_W = X_W+Y_W+D_W.
  - CNT_W = 16.
  - Error bit index constants ERR_OVF=0, ERR_MISROUTE=1.
- One sub-module, torus_msg_fifo:
  - Parameters DEPTH and MSG_W; ports push/pop/full/empty/count/head.
  - Instantiated twice: DEPTH for injection, 2 for ejection.
  - Same clk/rst convention.

Test Plan:
- Reset, then push 3 msgs (x=1,y=0,data=A/B/C) with i_ack held 0 -> i_v=1 from cycle after first push, head=A stable, u_rdy=1; then i_ack=1 for 3 cycles -> A,B,C in order, inj_cnt=3, i_v=0 after.
- DEPTH=4, push 5 with i_ack=0 -> u_rdy=0 after 4th, 5th not accepted; one i_ack -> u_rdy=1 next cycle, 5th accepted.
- d_rdy=0, o_v with (X,Y) on 3 consecutive cycles -> client_b=1 after 2nd write, 3rd dropped, err=2'b01, d_data=first msg.
- Same as above but d_rdy=1 on the 3rd cycle -> no drop, err=0, ej_cnt increments.
- o_v with o_x=X+1 -> err[1]=1 and d_v=1 with that msg; err stays set until reset.
- Assert rst low mid-transfer with 2 msgs queued in each path -> i_v=0, d_v=0, client_b=0, done=1 immediately, counters 0.
